bsg_parallel_in_serial_out_len: RTL

//  Serializer that feeds a SIPO stage: registers one parallel packet of up to
//  els_p words plus a length, then emits len_i+1 words one per handshake.

---
 rtl/bsg_parallel_in_serial_out_len.sv | 55 +++++
 1 files changed

// File: rtl/bsg_parallel_in_serial_out_len.sv
// bsg_parallel_in_serial_out_len: captures one parallel packet plus a length and emits len_i+1 serial words
module bsg_parallel_in_serial_out_len #(
  parameter int width_p = 8,
  parameter int els_p = 4,
  parameter bit hi_to_lo_p = 1'b0,
  parameter int lg_els_lp = (els_p == 1) ? 1 : $clog2(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  output logic                       ready_and_o,
  input  logic [els_p*width_p-1:0]   data_i,
  input  logic [lg_els_lp-1:0]       len_i,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  output logic                       first_o,
  output logic                       last_o,
  input  logic                       ready_and_i
);
  typedef enum logic {IDLE, SEND} state_e;
  localparam logic [lg_els_lp-1:0] max_len_lp = lg_els_lp'(els_p - 1);
  state_e state_r, state_n;
  logic [width_p-1:0] data_r [els_p];
  logic [lg_els_lp-1:0] len_r, len_n, idx_r, idx_n, len_eff, sel;
  logic busy, accept, fire;
  assign busy = state_r == SEND;
  assign len_eff = (len_i > max_len_lp) ? max_len_lp : len_i;
  assign sel = hi_to_lo_p ? len_r - idx_r : idx_r;
  assign v_o = busy;
  assign data_o = data_r[sel];
  assign first_o = busy & (idx_r == '0);
  assign last_o = busy & (idx_r == len_r);
  // Combinational ready path on the last word lets the next packet load with no bubble
  assign ready_and_o = ~busy | (last_o & ready_and_i);
  assign accept = v_i & ready_and_o;
  assign fire = busy & ready_and_i;
  always_comb begin
    state_n = accept ? SEND : (fire & last_o) ? IDLE : state_r;
    idx_n = accept ? '0 : (fire & ~last_o) ? idx_r + 1'b1 : idx_r;
    len_n = accept ? len_eff : len_r;
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_r <= IDLE;
      idx_r <= '0;
      len_r <= '0;
    end else begin
      state_r <= state_n;
      idx_r <= idx_n;
      len_r <= len_n;
    end
  always_ff @(posedge clk_i)
    if (accept)
      for (int i = 0; i < els_p; i++) data_r[i] <= data_i[i*width_p +: width_p];
endmodule
